// File: rtl/matmul_pkg.sv
// Shared definitions for the tiled matrix multiplier.
//   state_e   : controller states (IDLE, MAC, WB, DONE)
//   idx_width : index width for a dimension n, max(1, clog2(n))
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WB,
    DONE
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// Single multiply-accumulate lane.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : clear accumulator (has priority over en_i)
//   en_i     : add a_i*b_i (truncated to DW bits) into the accumulator
//   a_i, b_i : operands
//   acc_o    : current accumulator value
module mac_lane #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] acc_o
);

  logic [DW-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + DW'(a_i * b_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/tiled_matrix_multiplier.sv
// Tiled NxN integer matrix multiplier: C = A*B or C += A*B.
// Each output row is processed in groups of LANES columns; one k step per
// cycle in MAC, then one WB cycle commits the group into C.
//   clk, rst          : clock, asynchronous active-high reset
//   start, acc_mode   : launch a run (accepted in IDLE); 1 = accumulate into C
//   busy, done        : run in progress / one-cycle completion pulse
//   a_in/a_i/a_j/a_we : A write port (IDLE only)
//   b_in/b_i/b_j/b_we : B write port (IDLE only)
//   z_i/z_j/z_rd      : C read request (IDLE only)
//   z_stb/z_out       : C read data, valid for one cycle after the request
module tiled_matrix_multiplier
  import matmul_pkg::*;
#(
  parameter int  N     = 8,
  parameter int  LANES = 4,
  parameter int  DW    = 32,
  localparam int AW    = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          acc_mode,
  output logic          busy,
  output logic          done,
  input  logic [DW-1:0] a_in,
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] a_j,
  input  logic          a_we,
  input  logic [DW-1:0] b_in,
  input  logic [AW-1:0] b_i,
  input  logic [AW-1:0] b_j,
  input  logic          b_we,
  input  logic [AW-1:0] z_i,
  input  logic [AW-1:0] z_j,
  input  logic          z_rd,
  output logic          z_stb,
  output logic [DW-1:0] z_out
);

  localparam int G  = N / LANES;
  localparam int GW = idx_width(G);
  localparam int MW = idx_width(N * N);

  localparam logic [AW-1:0] K_LAST   = AW'(N - 1);
  localparam logic [AW-1:0] ROW_LAST = AW'(N - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);

  function automatic logic [MW-1:0] flat(input int unsigned r, input int unsigned c);
    return MW'(r * N + c);
  endfunction

  function automatic logic idx_ok(input int unsigned x);
    return x < N;
  endfunction

  // Storage (not reset)
  logic [DW-1:0] a_mem [N*N];
  logic [DW-1:0] b_mem [N*N];
  logic [DW-1:0] c_mem [N*N];

  state_e        state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] k_q, k_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          accm_q, accm_d;
  logic          done_q, done_d;
  logic          z_stb_q, z_stb_d;
  logic [DW-1:0] z_out_q, z_out_d;

  logic          lane_en, lane_clr, last_tile;
  logic [DW-1:0] a_op;
  logic [DW-1:0] b_op  [LANES];
  logic [DW-1:0] acc   [LANES];
  logic [MW-1:0] c_idx [LANES];

  assign last_tile = (grp_q == GRP_LAST) && (row_q == ROW_LAST);

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      k_q     <= '0;
      grp_q   <= '0;
      accm_q  <= 1'b0;
      done_q  <= 1'b0;
      z_stb_q <= 1'b0;
      z_out_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      grp_q   <= grp_d;
      accm_q  <= accm_d;
      done_q  <= done_d;
      z_stb_q <= z_stb_d;
      z_out_q <= z_out_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC:     if (k_q == K_LAST) state_d = WB;
      WB:      state_d = last_tile ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; done is registered off the DONE state so it lands one edge
  // after DONE is entered, while the FSM is already back in IDLE.
  always_comb begin
    busy     = (state_q == MAC) || (state_q == WB);
    done_d   = (state_q == DONE);
    lane_en  = (state_q == MAC);
    lane_clr = ((state_q == IDLE) && start) || (state_q == WB);
  end

  // Counters and latched mode
  always_comb begin
    row_d  = row_q;
    k_d    = k_q;
    grp_d  = grp_q;
    accm_d = accm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d  = '0;
          k_d    = '0;
          grp_d  = '0;
          accm_d = acc_mode;
        end
      end
      MAC: k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      WB: begin
        if (grp_q == GRP_LAST) begin
          grp_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Operand fetch for the current (row, k, group)
  always_comb begin
    a_op = a_mem[flat(32'(row_q), 32'(k_q))];
    for (int unsigned l = 0; l < LANES; l++) begin
      b_op[l]  = b_mem[flat(32'(k_q), 32'(grp_q) * LANES + l)];
      c_idx[l] = flat(32'(row_q), 32'(grp_q) * LANES + l);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(.DW(DW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr_i(lane_clr),
      .en_i (lane_en),
      .a_i  (a_op),
      .b_i  (b_op[l]),
      .acc_o(acc[l])
    );
  end

  // Array writes: host writes only in IDLE, result writeback in WB
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (a_we && idx_ok(32'(a_i)) && idx_ok(32'(a_j))) begin
        a_mem[flat(32'(a_i), 32'(a_j))] <= a_in;
      end
      if (b_we && idx_ok(32'(b_i)) && idx_ok(32'(b_j))) begin
        b_mem[flat(32'(b_i), 32'(b_j))] <= b_in;
      end
    end
    if (state_q == WB) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        c_mem[c_idx[l]] <= accm_q ? c_mem[c_idx[l]] + acc[l] : acc[l];
      end
    end
  end

  // Read port; out-of-range reads still strobe but return zero
  always_comb begin
    z_stb_d = (state_q == IDLE) && z_rd;
    z_out_d = z_out_q;
    if (z_stb_d) begin
      if (idx_ok(32'(z_i)) && idx_ok(32'(z_j))) begin
        z_out_d = c_mem[flat(32'(z_i), 32'(z_j))];
      end else begin
        z_out_d = '0;
      end
    end
  end

  assign done  = done_q;
  assign z_stb = z_stb_q;
  assign z_out = z_out_q;

endmodule

// File: tb/tb_tiled_matrix_multiplier.sv
module tb_tiled_matrix_multiplier;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t q_main[$];
  exp_t q6[$];
  exp_t q4[$];

  // Main DUT: defaults N=8, LANES=4, DW=32
  logic        rst = 1'b0, start = 1'b0, acc_mode = 1'b0;
  logic        busy, done;
  logic [31:0] a_in = '0, b_in = '0;
  logic [2:0]  a_i = '0, a_j = '0, b_i = '0, b_j = '0, z_i = '0, z_j = '0;
  logic        a_we = 1'b0, b_we = 1'b0, z_rd = 1'b0;
  logic        z_stb;
  logic [31:0] z_out;

  tiled_matrix_multiplier #(.N(8), .LANES(4), .DW(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
    .busy(busy), .done(done),
    .a_in(a_in), .a_i(a_i), .a_j(a_j), .a_we(a_we),
    .b_in(b_in), .b_i(b_i), .b_j(b_j), .b_we(b_we),
    .z_i(z_i), .z_j(z_j), .z_rd(z_rd), .z_stb(z_stb), .z_out(z_out)
  );

  // Small DUTs (N=6/LANES=3 and N=4/LANES=1) share one stimulus bus;
  // the N=4 instance only sees in-range requests.
  logic        s_start = 1'b0;
  logic [31:0] sa_in = '0, sb_in = '0;
  logic [2:0]  sa_i = '0, sa_j = '0, sb_i = '0, sb_j = '0, sz_i = '0, sz_j = '0;
  logic        sa_we = 1'b0, sb_we = 1'b0, sz_rd = 1'b0;
  logic        s6_busy, s6_done, s6_stb, s4_busy, s4_done, s4_stb;
  logic [31:0] s6_out, s4_out;
  logic        s4_a_we, s4_b_we, s4_z_rd;

  assign s4_a_we = sa_we && (sa_i < 3'd4) && (sa_j < 3'd4);
  assign s4_b_we = sb_we && (sb_i < 3'd4) && (sb_j < 3'd4);
  assign s4_z_rd = sz_rd && (sz_i < 3'd4) && (sz_j < 3'd4);

  tiled_matrix_multiplier #(.N(6), .LANES(3), .DW(32)) u_s6 (
    .clk(clk), .rst(rst), .start(s_start), .acc_mode(1'b0),
    .busy(s6_busy), .done(s6_done),
    .a_in(sa_in), .a_i(sa_i), .a_j(sa_j), .a_we(sa_we),
    .b_in(sb_in), .b_i(sb_i), .b_j(sb_j), .b_we(sb_we),
    .z_i(sz_i), .z_j(sz_j), .z_rd(sz_rd), .z_stb(s6_stb), .z_out(s6_out)
  );

  tiled_matrix_multiplier #(.N(4), .LANES(1), .DW(32)) u_s4 (
    .clk(clk), .rst(rst), .start(s_start), .acc_mode(1'b0),
    .busy(s4_busy), .done(s4_done),
    .a_in(sa_in), .a_i(sa_i[1:0]), .a_j(sa_j[1:0]), .a_we(s4_a_we),
    .b_in(sb_in), .b_i(sb_i[1:0]), .b_j(sb_j[1:0]), .b_we(s4_b_we),
    .z_i(sz_i[1:0]), .z_j(sz_j[1:0]), .z_rd(s4_z_rd), .z_stb(s4_stb), .z_out(s4_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Scoreboard monitors: every strobe must match the oldest pending entry
  initial begin : mon_main
    exp_t e;
    forever begin
      @(negedge clk);
      if (z_stb === 1'b1) begin
        if (q_main.size() == 0) chk("main unexpected z_stb", 32'd1, 32'd0);
        else begin
          e = q_main.pop_front();
          chk(e.name, z_out, e.val);
        end
      end
    end
  end

  initial begin : mon_s6
    exp_t e;
    forever begin
      @(negedge clk);
      if (s6_stb === 1'b1) begin
        if (q6.size() == 0) chk("n6 unexpected z_stb", 32'd1, 32'd0);
        else begin
          e = q6.pop_front();
          chk(e.name, s6_out, e.val);
        end
      end
    end
  end

  initial begin : mon_s4
    exp_t e;
    forever begin
      @(negedge clk);
      if (s4_stb === 1'b1) begin
        if (q4.size() == 0) chk("n4 unexpected z_stb", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          chk(e.name, s4_out, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main DUT helpers ----------------
  task automatic load_main(input bit wrap);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        a_i = 3'(i); a_j = 3'(j); b_i = 3'(i); b_j = 3'(j);
        a_in = wrap ? 32'hFFFF_FFFF : ((i == j) ? 32'd1 : 32'd0);
        b_in = wrap ? 32'hFFFF_FFFF : 32'(8 * i + j);
        a_we = 1'b1; b_we = 1'b1;
      end
    end
    @(negedge clk);
    a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic rd_main(input int i, input int j, input logic [31:0] req, input string tag);
    exp_t e;
    e.name = $sformatf("%s C[%0d][%0d]", tag, i, j);
    e.val  = req;
    q_main.push_back(e);
    @(negedge clk);
    z_i = 3'(i); z_j = 3'(j); z_rd = 1'b1;
    @(negedge clk);
    z_rd = 1'b0;
  endtask

  // Launches a run and checks done lands exactly lat edges after the start edge.
  // With poke set, busy-time writes/starts/reads are issued and must be ignored.
  task automatic run_main(input logic mode, input int lat, input bit poke, input string tag);
    int  e;
    bit  seen;
    @(negedge clk);
    start = 1'b1; acc_mode = mode;
    @(posedge clk);
    #1 chk({tag, " busy after start"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0; acc_mode = 1'b0;
    e = 0; seen = 1'b0;
    while (!seen && e < lat + 20) begin
      @(posedge clk);
      e++;
      #1;
      if (done === 1'b1) seen = 1'b1;
      if (poke && e >= 3 && e <= 6) chk({tag, " z_stb while busy"}, 32'(z_stb), 32'd0);
      if (poke && e == 2) begin
        a_i = '0; a_j = '0; a_in = 32'd5; a_we = 1'b1;
        start = 1'b1; acc_mode = 1'b1;
        z_i = '0; z_j = '0; z_rd = 1'b1;
      end
      if (poke && e == 6) begin
        a_we = 1'b0; start = 1'b0; acc_mode = 1'b0; z_rd = 1'b0;
      end
    end
    chk({tag, " done edge"}, 32'(e), 32'(lat));
    @(posedge clk);
    #1;
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " busy after done"}, 32'(busy), 32'd0);
  endtask

  // ---------------- small DUT helpers ----------------
  logic [31:0] ma [6][6];
  logic [31:0] mb [6][6];

  function automatic logic [31:0] ref_c(input int n, input int i, input int j);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s = s + ma[i][k] * mb[k][j];
    return s;
  endfunction

  task automatic rd_small(input int i, input int j, input logic [31:0] r6, input logic [31:0] r4);
    exp_t e;
    e.name = $sformatf("n6 C[%0d][%0d]", i, j);
    e.val  = r6;
    q6.push_back(e);
    if (i < 4 && j < 4) begin
      e.name = $sformatf("n4 C[%0d][%0d]", i, j);
      e.val  = r4;
      q4.push_back(e);
    end
    @(negedge clk);
    sz_i = 3'(i); sz_j = 3'(j); sz_rd = 1'b1;
    @(negedge clk);
    sz_rd = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int  e, e6, e4, npulse;

    #2 rst = 1'b1;
    #3;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset z_stb", 32'(z_stb), 32'd0);
    chk("reset z_out", z_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Identity: A=I, B[i][j]=8i+j
    load_main(1'b0);
    run_main(1'b0, 145, 1'b0, "identity");
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rd_main(i, j, 32'(8 * i + j), "identity");

    // Accumulate on top of the identity result
    run_main(1'b1, 145, 1'b0, "accum");
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rd_main(i, j, 32'(2 * (8 * i + j)), "accum");

    // Reset at edge 50 of a run
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    repeat (160) begin
      @(posedge clk);
      #1 if (done === 1'b1) npulse++;
    end
    chk("midreset no done pulse", 32'(npulse), 32'd0);
    run_main(1'b0, 145, 1'b0, "rerun");
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rd_main(i, j, 32'(8 * i + j), "rerun");

    // Busy-time write/start/read must all be ignored
    run_main(1'b0, 145, 1'b1, "busyign");
    npulse = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done === 1'b1) npulse++;
    end
    chk("busyign extra done", 32'(npulse), 32'd0);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rd_main(i, j, 32'(8 * i + j), "busyign");

    // Wrap: (-1)*(-1) summed 8 times
    load_main(1'b1);
    run_main(1'b0, 145, 1'b0, "wrap");
    for (int i = 0; i < 8; i += 3)
      for (int j = 0; j < 8; j++) rd_main(i, j, 32'd8, "wrap");

    // Small configurations
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        ma[i][j] = 32'h9E37_79B9 * 32'(i * 6 + j + 1);
        mb[i][j] = 32'h7F4A_7C15 * 32'(i + 2 * j + 3) - 32'd1000;
        @(negedge clk);
        sa_i = 3'(i); sa_j = 3'(j); sb_i = 3'(i); sb_j = 3'(j);
        sa_in = ma[i][j]; sb_in = mb[i][j];
        sa_we = 1'b1; sb_we = 1'b1;
      end
    end
    // Out-of-range writes: (0,6) would alias A[1][0]/B[1][0] if not dropped
    @(negedge clk);
    sa_i = 3'd0; sa_j = 3'd6; sb_i = 3'd0; sb_j = 3'd6;
    sa_in = 32'hDEAD_BEEF; sb_in = 32'hCAFE_F00D;
    @(negedge clk);
    sa_i = 3'd7; sa_j = 3'd0; sb_i = 3'd7; sb_j = 3'd0;
    @(negedge clk);
    sa_we = 1'b0; sb_we = 1'b0;

    s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    e = 0; e6 = 0; e4 = 0;
    while ((e6 == 0 || e4 == 0) && e < 120) begin
      @(posedge clk);
      e++;
      #1;
      if (s6_done === 1'b1 && e6 == 0) e6 = e;
      if (s4_done === 1'b1 && e4 == 0) e4 = e;
    end
    chk("n6 done edge", 32'(e6), 32'd85);
    chk("n4 done edge", 32'(e4), 32'd81);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) rd_small(i, j, ref_c(6, i, j), ref_c(4, i, j));
    rd_small(0, 6, 32'd0, 32'd0);
    rd_small(6, 1, 32'd0, 32'd0);
    rd_small(7, 7, 32'd0, 32'd0);

    repeat (5) @(negedge clk);
    chk("main scoreboard drained", 32'(q_main.size()), 32'd0);
    chk("n6 scoreboard drained", 32'(q6.size()), 32'd0);
    chk("n4 scoreboard drained", 32'(q4.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tiled_matrix_multiplier.md
TILED_MATRIX_MULTIPLIER -- requirements
Module: tiled_matrix_multiplier

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning the square matrix dimension.
REQ-002 The module SHALL have parameter LANES, default 4, meaning the number of parallel MAC lanes; N mod LANES SHALL be 0 and LANES SHALL be at least 1.
REQ-003 The module SHALL have parameter DW, default 32, meaning the element width as two's-complement integers.
REQ-004 The module SHALL define the local constant AW = max(1, clog2(N)) as the index width.
REQ-005 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-006 The module SHALL have the following ports:
  clk  in  1  system clock
  rst  in  1  asynchronous reset, active-high
  start  in  1  pulse that starts C = A*B (or C += A*B)
  acc_mode  in  1  sampled with start: 0 = overwrite C, 1 = accumulate into C
  busy  out  1  computation in progress
  done  out  1  one-cycle completion pulse
  a_in  in  DW  A write data
  a_i, a_j  in  AW  A row and column
  a_we  in  1  A write enable
  b_in  in  DW  B write data
  b_i, b_j  in  AW  B row and column
  b_we  in  1  B write enable
  z_i, z_j  in  AW  C read row and column
  z_rd  in  1  C read request
  z_stb  out  1  z_out valid strobe
  z_out  out  DW  C read data

Function
REQ-007 The FSM SHALL have four states: IDLE, MAC, WB, DONE.
REQ-008 In IDLE, a_we and b_we SHALL write A[a_i][a_j] and B[b_i][b_j] on the clock edge; writes in any other state SHALL be dropped.
REQ-009 In IDLE, start=1 SHALL latch acc_mode, clear the row, column-group and k counters, clear all lane accumulators, and move to MAC.
REQ-010 In MAC, for k = 0..N-1 (one k per cycle), lane l SHALL add A[row][k]*B[k][grp*LANES+l] to its accumulator, with the product truncated to DW bits.
REQ-011 After the k=N-1 cycle, the FSM SHALL go to WB; in WB each lane SHALL write C[row][grp*LANES+l] = acc, or C + acc when acc_mode is latched, then clear its accumulator.
REQ-012 From WB, the FSM SHALL advance grp, then row (grp wraps to 0), and return to MAC; after the last row and last group it SHALL go to DONE.
REQ-013 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-014 done SHALL assert exactly G*(N+1)+1 edges after the edge that samples start, where G = N*N/LANES (145 at the defaults).
REQ-015 busy SHALL be 1 in MAC and WB, and 0 in IDLE and DONE.
REQ-016 start SHALL be ignored while not in IDLE.
REQ-017 All arithmetic SHALL be modulo 2^DW; overflow SHALL wrap silently.
REQ-018 z_rd in IDLE SHALL register C[z_i][z_j] into z_out and assert z_stb on the next cycle for exactly one cycle.
REQ-019 z_rd outside IDLE SHALL be ignored, with z_stb remaining 0.
REQ-020 z_out SHALL hold its last value between reads.
REQ-021 An out-of-range index (at least N) SHALL make the write a no-op and make the read return 0 with z_stb still asserted.
REQ-022 When start and a_we or b_we occur in the same IDLE cycle, the write SHALL commit first, and the computation SHALL use the new value.

Reset
REQ-023 rst=1 SHALL immediately force the IDLE state, busy=0, done=0, z_stb=0, z_out=0, all counters 0, all accumulators 0, and latched acc_mode=0.
REQ-024 The A, B and C arrays SHALL NOT be reset; after rst asserts mid-computation, C contents SHALL be unspecified and done SHALL NOT pulse for the aborted run.

Structure
REQ-025 Shared package matmul_pkg SHALL hold the state enum (IDLE, MAC, WB, DONE) and a clog2-based index-width function; N, LANES and DW SHALL remain module parameters.
REQ-026 Each lane SHALL be an instance of sub-module mac_lane (DW-bit multiply-accumulate, clear, enable), generated LANES times.
REQ-027 The top level SHALL contain the FSM, counters, A/B/C arrays and read port.

Verification
REQ-028 Identity test: with N=8, LANES=4, A=I, B[i][j]=8i+j, acc_mode=0 and start -> done at edge 145, then every read of C[i][j] returns 8i+j with z_stb for one cycle.
REQ-029 Accumulate test: after REQ-028, keep A and B and start with acc_mode=1 -> C[i][j]=2*(8i+j).
REQ-030 Wrap test: A and B all 0xFFFFFFFF with DW=32, N=8 and acc_mode=0 -> every C element reads 8.
REQ-031 Reset-mid-run test: assert rst at edge 50 after start -> busy=0 and done=0 immediately, and done does not pulse; then rerun REQ-028 -> correct result with done at edge 145.
REQ-032 Busy-ignore test: during busy, a_we sets A[0][0]=5, start=1 and z_rd=1 -> A is unchanged, a single done pulse occurs, z_stb stays 0, and the result matches REQ-028.
REQ-033 Parameter test: N=6, LANES=3 and N=4, LANES=1 with random A and B -> C matches the reference model, and done occurs at G*(N+1)+1 (85 and 81 respectively).
